// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin arbitration slice.
package rr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int ARB_N    = 8;
  localparam int ARB_IDXW = 3;

  // Rotating pointer step: wraps N-1 back to 0.
  function automatic int next_ptr(input int idx, input int n = ARB_N);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_grant_dispatcher.sv
// Registers the encoder's winner as a held one-hot grant and rotates the priority pointer on release.
// Optional forced release after MAX_HOLD cycles: define RR_GRANT_HOLD_TIMEOUT_EN.
module rr_grant_dispatcher
  import rr_arb_pkg::*;
#(
  parameter int N        = ARB_N,
  parameter int IDXW     = ARB_IDXW,
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IDXW-1:0] enc_grant,
  input  logic            enc_valid,
  input  logic            done,
  output logic [N-1:0]    gnt_onehot,
  output logic            gnt_valid,
  output logic [IDXW-1:0] gnt_idx,
  output logic [IDXW-1:0] prio,
  output logic            timeout,
  output state_t          fsm_state
);

  // Handshake: a grant is offered while gnt_valid=1 and retired by done=1 at a
  // GRANT-state edge; enc_valid/enc_grant are consumed only at an IDLE edge.

  localparam logic [IDXW:0] N_LIM = (IDXW+1)'(N);

  function automatic logic [N-1:0] decode(input logic [IDXW-1:0] idx);
    return N'(1) << idx;
  endfunction

  state_t          state_q, state_d;
  logic [N-1:0]    onehot_q, onehot_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [IDXW-1:0] prio_q, prio_d;
  logic            timeout_q, timeout_d;
  logic            accept, release_now, force_rel;

`ifdef RR_GRANT_HOLD_TIMEOUT_EN
  localparam int            CW        = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  logic [CW-1:0] hold_q, hold_d;

  // Counter sits at zero in IDLE, so it starts from zero on every GRANT entry.
  always_comb begin
    hold_d = '0;
    if (state_q == GRANT && hold_q != HOLD_LAST) hold_d = hold_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_q <= '0;
    else        hold_q <= hold_d;
  end

  assign force_rel = (state_q == GRANT) && (hold_q == HOLD_LAST) && !done;
`else
  localparam int unused_max_hold = MAX_HOLD;
  assign force_rel = 1'b0;
`endif

  assign accept      = (state_q == IDLE) && enc_valid && ({1'b0, enc_grant} < N_LIM);
  assign release_now = (state_q == GRANT) && (done || force_rel);

  always_comb begin
    state_d   = state_q;
    onehot_d  = onehot_q;
    idx_d     = idx_q;
    prio_d    = prio_q;
    timeout_d = 1'b0;
    if (accept) begin
      state_d  = GRANT;
      idx_d    = enc_grant;
      onehot_d = decode(enc_grant);
    end else if (release_now) begin
      state_d   = IDLE;
      onehot_d  = '0;
      prio_d    = IDXW'(next_ptr(int'(idx_q), N));
      timeout_d = !done;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      onehot_q  <= '0;
      idx_q     <= '0;
      prio_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      onehot_q  <= onehot_d;
      idx_q     <= idx_d;
      prio_q    <= prio_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt_onehot = onehot_q;
  assign gnt_valid  = (state_q == GRANT);
  assign gnt_idx    = idx_q;
  assign prio       = prio_q;
  assign timeout    = timeout_q;
  assign fsm_state  = state_q;

endmodule

// File: tb/tb_rr_grant_dispatcher.sv
// Self-checking bench for rr_grant_dispatcher: vector table, corner sequences, encoder loop, random vs model.
module tb_rr_grant_dispatcher;
  import rr_arb_pkg::*;

  localparam int N        = 8;
  localparam int IDXW     = 3;
  localparam int MAX_HOLD = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [IDXW-1:0] enc_grant = '0;
  logic            enc_valid = 1'b0;
  logic            done = 1'b0;
  logic [N-1:0]    gnt_onehot;
  logic            gnt_valid;
  logic [IDXW-1:0] gnt_idx;
  logic [IDXW-1:0] prio;
  logic            timeout;
  state_t          fsm_state;

  int checks = 0;
  int errors = 0;

  rr_grant_dispatcher #(.N(N), .IDXW(IDXW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .enc_grant(enc_grant), .enc_valid(enc_valid),
    .done(done), .gnt_onehot(gnt_onehot), .gnt_valid(gnt_valid),
    .gnt_idx(gnt_idx), .prio(prio), .timeout(timeout), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // reference model: who holds the grant, where the pointer is, how long it has been held
  bit m_held;
  int m_owner, m_ptr, m_cnt;
  bit m_to;

  task automatic model_reset();
    m_held = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_to = 0;
  endtask

  task automatic model_step(input bit ev, input int eg, input bit dn);
    m_to = 0;
    if (m_held) begin
      if (dn) begin
        m_held = 0; m_ptr = (m_owner + 1) % N;
      end
`ifdef RR_GRANT_HOLD_TIMEOUT_EN
      else if (m_cnt == MAX_HOLD - 1) begin
        m_held = 0; m_ptr = (m_owner + 1) % N; m_to = 1;
      end else m_cnt++;
`endif
    end else if (ev && eg < N) begin
      m_held = 1; m_owner = eg; m_cnt = 0;
    end
  endtask

  function automatic int enc_pick(input logic [N-1:0] req, input int p);
    for (int k = 0; k < N; k++) if (req[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  // driver tasks
  task automatic apply(input bit ev, input int eg, input bit dn);
    enc_valid = ev; enc_grant = IDXW'(eg); done = dn;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enc_valid = 0; enc_grant = '0; done = 0;
    #3;
    check("reset_valid", int'(gnt_valid), 0);
    check("reset_onehot", int'(gnt_onehot), 0);
    check("reset_prio", int'(prio), 0);
    check("reset_timeout", int'(timeout), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic       ev;
    logic [2:0] eg;
    logic       dn;
    logic       e_valid;
    logic [2:0] e_idx;
    logic [7:0] e_oh;
    logic [2:0] e_prio;
  } vec_t;

  vec_t vecs[13];
  logic [7:0] exp_q[$];
  int grants[$];

  initial begin
    vecs[0]  = '{1'b1, 3'd5, 1'b1, 1'b1, 3'd5, 8'h20, 3'd5 - 3'd5}; // done on latch edge ignored
    vecs[1]  = '{1'b1, 3'd6, 1'b0, 1'b1, 3'd5, 8'h20, 3'd0};        // no preemption
    vecs[2]  = '{1'b0, 3'd0, 1'b1, 1'b0, 3'd5, 8'h00, 3'd6};
    vecs[3]  = '{1'b0, 3'd3, 1'b1, 1'b0, 3'd5, 8'h00, 3'd6};        // done in IDLE ignored
    vecs[4]  = '{1'b1, 3'd7, 1'b0, 1'b1, 3'd7, 8'h80, 3'd6};
    vecs[5]  = '{1'b1, 3'd0, 1'b1, 1'b0, 3'd7, 8'h00, 3'd0};        // wrap
    vecs[6]  = '{1'b1, 3'd0, 1'b0, 1'b1, 3'd0, 8'h01, 3'd0};
    vecs[7]  = '{1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 8'h00, 3'd1};
    vecs[8]  = '{1'b1, 3'd2, 1'b0, 1'b1, 3'd2, 8'h04, 3'd1};
    vecs[9]  = '{1'b1, 3'd6, 1'b0, 1'b1, 3'd2, 8'h04, 3'd1};
    vecs[10] = '{1'b1, 3'd6, 1'b1, 1'b0, 3'd2, 8'h00, 3'd3};        // gap cycle follows
    vecs[11] = '{1'b1, 3'd6, 1'b0, 1'b1, 3'd6, 8'h40, 3'd3};
    vecs[12] = '{1'b0, 3'd0, 1'b1, 1'b0, 3'd6, 8'h00, 3'd7};

    do_reset();

    for (int i = 0; i < 13; i++) begin
      apply(vecs[i].ev, int'(vecs[i].eg), vecs[i].dn);
      check($sformatf("vec%0d_valid", i), int'(gnt_valid), int'(vecs[i].e_valid));
      check($sformatf("vec%0d_onehot", i), int'(gnt_onehot), int'(vecs[i].e_oh));
      check($sformatf("vec%0d_prio", i), int'(prio), int'(vecs[i].e_prio));
      check($sformatf("vec%0d_timeout", i), int'(timeout), 0);
      if (vecs[i].e_valid) check($sformatf("vec%0d_idx", i), int'(gnt_idx), int'(vecs[i].e_idx));
    end

    // reset mid-grant drops everything without a clock edge
    apply(1, 5, 0);
    check("pre_rst_valid", int'(gnt_valid), 1);
    rst_n = 1'b0;
    #2;
    check("midrst_valid", int'(gnt_valid), 0);
    check("midrst_onehot", int'(gnt_onehot), 0);
    check("midrst_prio", int'(prio), 0);
    check("midrst_state", int'(fsm_state), int'(IDLE));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // long hold on idx 3
    do_reset();
    apply(1, 3, 0);
    check("hold3_idx", int'(gnt_idx), 3);
    enc_valid = 0;
`ifdef RR_GRANT_HOLD_TIMEOUT_EN
    for (int c = 1; c < MAX_HOLD; c++) begin
      apply(0, 0, 0);
      check($sformatf("to_hold%0d", c), int'(gnt_valid), 1);
      check($sformatf("to_quiet%0d", c), int'(timeout), 0);
    end
    apply(0, 0, 0);
    check("to_release_valid", int'(gnt_valid), 0);
    check("to_pulse", int'(timeout), 1);
    check("to_prio", int'(prio), 4);
    apply(0, 0, 0);
    check("to_pulse_end", int'(timeout), 0);
`else
    for (int c = 0; c < 40; c++) begin
      apply(0, 0, 0);
      check($sformatf("hold%0d_valid", c), int'(gnt_valid), 1);
      check($sformatf("hold%0d_timeout", c), int'(timeout), 0);
    end
    apply(0, 0, 1);
    check("hold_release_valid", int'(gnt_valid), 0);
    check("hold_release_prio", int'(prio), 4);
`endif

    // encoder loop with requests 6 and 7, done one cycle after each grant
    do_reset();
    begin
      logic [N-1:0] req;
      bit prev_valid;
      int idle_run;
      req = 8'hC0; prev_valid = 0; idle_run = 0;
      grants.delete();
      for (int c = 0; c < 12; c++) begin
        enc_valid = |req;
        enc_grant = IDXW'(enc_pick(req, int'(prio)));
        done = gnt_valid;
        @(posedge clk); #1;
        if (gnt_valid && !prev_valid) begin
          grants.push_back(int'(gnt_idx));
          if (grants.size() > 1) check($sformatf("loop_gap%0d", grants.size()), idle_run, 1);
        end
        idle_run = gnt_valid ? 0 : idle_run + 1;
        prev_valid = gnt_valid;
      end
      check("loop_grant_count_ok", int'(grants.size() >= 4), 1);
      exp_q = '{8'd6, 8'd7, 8'd6, 8'd7};
      for (int g = 0; g < 4 && g < grants.size(); g++)
        check($sformatf("loop_grant%0d", g), grants[g], int'(exp_q[g]));
    end

    // randomized stimulus against the model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      bit ev, dn;
      int eg;
      logic [N-1:0] e_oh;
      ev = ($urandom_range(0, 3) != 0);
      eg = $urandom_range(0, N - 1);
      dn = ($urandom_range(0, 7) == 0);
      model_step(ev, eg, dn);
      apply(ev, eg, dn);
      e_oh = m_held ? (N'(1) << m_owner) : '0;
      check("rand_valid", int'(gnt_valid), int'(m_held));
      check("rand_onehot", int'(gnt_onehot), int'(e_oh));
      check("rand_prio", int'(prio), m_ptr);
      check("rand_timeout", int'(timeout), int'(m_to));
      if (m_held) check("rand_idx", int'(gnt_idx), m_owner);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_grant_dispatcher.md
Name: rr_grant_dispatcher

Overview:
- Consumer side of the dynamic priority encoder. Takes its encoded grant index and valid flag, registers them, and drives a one-hot grant back to the requesters.
- Holds the grant until the owning requester signals done.
- Advances the rotating priority pointer, which feeds back to the encoder's priority input, to give round-robin fairness.

Parameters:
- N, 8, number of requesters (width of one-hot grant).
- IDXW, 3, index width; must equal clog2(N).
- MAX_HOLD, 16, cycles before forced release (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enc_grant  input  IDXW  encoded winner index from the encoder.
- enc_valid  input  1  encoder has at least one active request.
- done  input  1  current grant holder finished; sampled only in GRANT.
- gnt_onehot  output  N  registered one-hot grant to the requesters.
- gnt_valid  output  1  a grant is currently held.
- gnt_idx  output  IDXW  registered index of the current holder.
- priority  output  IDXW  rotating pointer driven to the encoder's priority input.
- timeout  output  1  one-cycle pulse on forced release (feature only; tied 0 otherwise).

Behaviour:
- Reset (async assert, sync deassert at the board level): gnt_onehot=0, gnt_valid=0, gnt_idx=0, priority=0, timeout=0, state=IDLE. Reset asserted mid-grant drops the grant immediately, without waiting for done.
- States: IDLE, GRANT.
- IDLE:
  - If enc_valid=1 and enc_grant<N at edge k: latch gnt_idx=enc_grant, gnt_onehot=1<<enc_grant, gnt_valid=1, go to GRANT. Grant is visible after edge k (one-cycle latency).
  - If enc_grant>=N (only possible when N is not a power of 2): ignore the request and stay in IDLE.
  - done is ignored in IDLE.
- GRANT:
  - Outputs held stable; enc_grant and enc_valid are ignored (no preemption).
  - done=1 at an edge: clear gnt_onehot and gnt_valid, set priority=(gnt_idx+1) mod N, go to IDLE.
  - Wrap: gnt_idx=N-1 gives priority=0.
- Minimum gap: after release, at least one IDLE cycle with gnt_valid=0 occurs before the next grant. The encoder re-evaluates combinationally with the new priority during that cycle.
- done asserted in the same cycle as the grant latch (IDLE edge) has no effect. Release requires done while in GRANT.
- gnt_onehot is always either zero or exactly one-hot. gnt_valid == |gnt_onehot.
- priority changes only on release or reset.

Optional Feature:
- Macro: RR_GRANT_HOLD_TIMEOUT_EN.
- When defined:
  - Hold counter (clog2(MAX_HOLD+1) bits) clears on entry to GRANT and increments each GRANT cycle.
  - If done is not seen when the counter reaches MAX_HOLD-1, a forced release occurs at that edge. Effect is identical to done, plus timeout=1 for one cycle.
  - done and a timeout on the same edge count as a normal release; timeout stays 0.
- When undefined: no counter, timeout tied 0, the grant is held indefinitely until done.

Decomposition:
- Shared package rr_arb_pkg:
  - state enum {IDLE, GRANT};
  - constants ARB_N=8, ARB_IDXW=3;
  - function next_ptr(idx) implementing mod-N increment.
- No sub-module required. The one-hot decode is a small function; the hold counter stays inline under the macro.

Test Plan:
- Reset mid-grant: hold grant on idx 5, assert rst_n=0 -> gnt_onehot=0, gnt_valid=0, priority=0 immediately, without a clock edge.
- Basic grant: enc_valid=1, enc_grant=5 -> next cycle gnt_onehot=8'b0010_0000, gnt_idx=5. Pulse done -> gnt_valid=0, priority=6.
- Wrap-around: grant idx 7, done -> priority=0. Next enc_grant=0 is granted after one IDLE gap cycle, gnt_onehot=8'b0000_0001.
- No preemption and no done in IDLE:
  - while holding idx 2, change enc_grant to 6 -> gnt_idx stays 2;
  - done in IDLE with enc_valid=0 -> no state change, priority unchanged.
- Encoder loop: connect the real encoder, in=8'b1100_0000, requesters drop done one cycle after grant -> grants alternate 6,7,6,7, each separated by one idle cycle.
- With RR_GRANT_HOLD_TIMEOUT_EN, MAX_HOLD=16: hold idx 3, never assert done -> forced release after 16 GRANT cycles, timeout pulses once, priority=4.
